mode_select: RTL and testbench

Debounced push-button mode selector producing the 2-bit mode `S` consumed by the LED pattern generator. Two raw, bouncing buttons (next / previous) are synchronised, debounced and converted into single mode steps, with optional auto-repeat while a button is held. `S` wraps modulo 4. A one-cycle `step` strobe marks every mode change. The block runs on the undivided board clock, upstream of the divided-clock pattern logic.

---
 rtl/mode_select.sv | 153 +++++++++++++++
 tb/tb_mode_select.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mode_select.sv
// Debounced next/prev push-button mode selector: 2-bit wrapping mode S with a
// one-cycle step strobe and the direction of the last step.
module mode_select #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_next,
  input  logic       btn_prev,
  output logic [1:0] S,
  output logic       step,
  output logic       dir
);

  localparam int DB_W    = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = $clog2(RPT_MAX) + 1;

  localparam logic [1:0] ST_RELEASED = 2'd0;
  localparam logic [1:0] ST_HELD     = 2'd1;
  localparam logic [1:0] ST_REPEAT   = 2'd2;

  logic [1:0] btn_raw;
  logic [1:0] req;

  assign btn_raw = {btn_prev, btn_next};

  // Index 0 is the next button, index 1 the prev button.
  for (genvar gi = 0; gi < 2; gi++) begin : g_btn
    logic [1:0]       sync_q;
    logic             stable_q, stable_d;
    logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
    logic             armed_q, armed_d;
    logic [DB_W-1:0]  arm_cnt_q, arm_cnt_d;
    logic [1:0]       state_q, state_d;
    logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
    logic             req_b;
    logic             sync_lvl;

    assign sync_lvl = sync_q[1];
    assign req[gi]  = req_b;

    always_comb begin
      stable_d = stable_q;
      db_cnt_d = '0;
      if (sync_lvl != stable_q) begin
        if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          stable_d = sync_lvl;
        end else begin
          db_cnt_d = db_cnt_q + 1'b1;
        end
      end
    end

    // A button held through reset must first be seen released (debounced)
    // before its next rising edge may step the mode.
    always_comb begin
      armed_d   = armed_q;
      arm_cnt_d = '0;
      if (!armed_q && !sync_lvl) begin
        if (arm_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          armed_d = 1'b1;
        end else begin
          arm_cnt_d = arm_cnt_q + 1'b1;
        end
      end
    end

    always_comb begin
      state_d   = state_q;
      rpt_cnt_d = rpt_cnt_q;
      req_b     = 1'b0;
      case (state_q)
        ST_RELEASED: begin
          if (stable_q && armed_q) begin
            req_b     = 1'b1;
            state_d   = ST_HELD;
            rpt_cnt_d = RPT_W'(REPEAT_DELAY);
          end
        end
        ST_HELD, ST_REPEAT: begin
          if (!stable_q) begin
            state_d = ST_RELEASED;
          end else if (REPEAT_DELAY != 0) begin
            if (rpt_cnt_q == RPT_W'(1)) begin
              req_b     = 1'b1;
              state_d   = ST_REPEAT;
              rpt_cnt_d = RPT_W'(REPEAT_PERIOD);
            end else begin
              rpt_cnt_d = rpt_cnt_q - 1'b1;
            end
          end
        end
        default: state_d = ST_RELEASED;
      endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync_q    <= '0;
        stable_q  <= 1'b0;
        db_cnt_q  <= '0;
        armed_q   <= 1'b0;
        arm_cnt_q <= '0;
        state_q   <= ST_RELEASED;
        rpt_cnt_q <= '0;
      end else begin
        sync_q    <= {sync_q[0], btn_raw[gi]};
        stable_q  <= stable_d;
        db_cnt_q  <= db_cnt_d;
        armed_q   <= armed_d;
        arm_cnt_q <= arm_cnt_d;
        state_q   <= state_d;
        rpt_cnt_q <= rpt_cnt_d;
      end
    end
  end

  logic [1:0] s_q, s_d;
  logic       step_q, step_d;
  logic       dir_q, dir_d;

  // Coincident next and prev requests cancel each other.
  always_comb begin
    s_d    = s_q;
    dir_d  = dir_q;
    step_d = 1'b0;
    if (req[0] ^ req[1]) begin
      step_d = 1'b1;
      dir_d  = req[0];
      s_d    = req[0] ? (s_q + 2'd1) : (s_q - 2'd1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q    <= 2'd0;
      step_q <= 1'b0;
      dir_q  <= 1'b0;
    end else begin
      s_q    <= s_d;
      step_q <= step_d;
      dir_q  <= dir_d;
    end
  end

  assign S    = s_q;
  assign step = step_q;
  assign dir  = dir_q;

endmodule

// File: tb/tb_mode_select.sv
// Self-checking bench for mode_select: press schedules are turned into
// expected step edges arithmetically and folded into a mod-4 mode model.
module tb_mode_select;
  localparam int D   = 4;
  localparam int RD  = 10;
  localparam int RP  = 5;
  localparam int WIN = 512;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       btn_next;
  logic       btn_prev;
  logic [1:0] S;
  logic       step;
  logic       dir;

  always #5 clk = ~clk;

  mode_select #(
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_next(btn_next),
    .btn_prev(btn_prev),
    .S       (S),
    .step    (step),
    .dir     (dir)
  );

  int n_checks = 0;
  int n_fails  = 0;
  bit raw_n [WIN];
  bit raw_p [WIN];
  bit req_n [WIN];
  bit req_p [WIN];
  int s_m   = 0;
  bit dir_m = 1'b0;

  function automatic void clear_window();
    for (int k = 0; k < WIN; k++) begin
      raw_n[k] = 1'b0; raw_p[k] = 1'b0; req_n[k] = 1'b0; req_p[k] = 1'b0;
    end
  endfunction

  function automatic void mark(bit is_next, int e);
    if (e < WIN) begin
      if (is_next) req_n[e] = 1'b1; else req_p[e] = 1'b1;
    end
  endfunction

  // Raw high on cycles [p, r-1]: first step D+2 edges after p, repeats after
  // RD then every RP, as long as the debounced level is still high (until r+1+D).
  function automatic void add_press(bit is_next, int p, int r);
    int fall;
    int e;
    fall = r + 1 + D;
    for (int k = p; k < r && k < WIN; k++) begin
      if (is_next) raw_n[k] = 1'b1; else raw_p[k] = 1'b1;
    end
    e = p + 2 + D;
    mark(is_next, e);
    if (RD != 0) begin
      e = e + RD;
      while (e <= fall) begin
        mark(is_next, e);
        e = e + RP;
      end
    end
  endfunction

  function automatic bit model_step(int k);
    if (req_n[k] != req_p[k]) begin
      s_m   = req_n[k] ? (s_m + 1) % 4 : (s_m + 3) % 4;
      dir_m = req_n[k];
      return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic drive(int k);
    btn_next = raw_n[k];
    btn_prev = raw_p[k];
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bit st;
    rst_n = 1'b0; btn_next = 1'b1; btn_prev = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (S !== 2'd0 || step !== 1'b0 || dir !== 1'b0) begin
      n_fails++;
      $display("FAIL reset_values: S=%0d step=%0b dir=%0b, expected 0 0 0", S, step, dir);
    end
    @(negedge clk);
    rst_n = 1'b1;
    s_m = 0; dir_m = 1'b0;
    clear_window();
    for (int k = 0; k < 30; k++) raw_n[k] = 1'b1;
    add_press(1'b1, 40, 52);
    for (int k = 0; k < 70; k++) begin
      drive(k);
      st = model_step(k);
      n_checks++;
      if (S !== 2'(s_m) || step !== st || dir !== dir_m) begin
        n_fails++;
        $display("FAIL reset_held cycle %0d: S=%0d step=%0b dir=%0b, expected S=%0d step=%0b dir=%0b",
                 k, S, step, dir, s_m, st, dir_m);
      end
    end
  endtask

  task automatic test_clean_next();
    bit st;
    clear_window();
    add_press(1'b1, 0, 8);
    add_press(1'b1, 20, 28);
    add_press(1'b1, 40, 48);
    for (int k = 0; k < 70; k++) begin
      drive(k);
      st = model_step(k);
      n_checks++;
      if (S !== 2'(s_m) || step !== st || dir !== dir_m) begin
        n_fails++;
        $display("FAIL clean_next cycle %0d: S=%0d step=%0b dir=%0b, expected S=%0d step=%0b dir=%0b",
                 k, S, step, dir, s_m, st, dir_m);
      end
    end
  endtask

  task automatic test_bounce_prev();
    bit st;
    int t;
    int h;
    clear_window();
    t = 0;
    while (t < 30) begin
      h = int'($urandom_range(1, 3));
      for (int k = t; k < t + h && k < 30; k++) raw_p[k] = 1'b1;
      t = t + h + int'($urandom_range(1, 3));
    end
    add_press(1'b0, 40, 52);
    for (int k = 0; k < 70; k++) begin
      drive(k);
      st = model_step(k);
      n_checks++;
      if (S !== 2'(s_m) || step !== st || dir !== dir_m) begin
        n_fails++;
        $display("FAIL bounce_prev cycle %0d: S=%0d step=%0b dir=%0b, expected S=%0d step=%0b dir=%0b",
                 k, S, step, dir, s_m, st, dir_m);
      end
    end
  endtask

  task automatic test_auto_repeat();
    bit st;
    clear_window();
    add_press(1'b1, 0, 35);
    for (int k = 0; k < 60; k++) begin
      drive(k);
      st = model_step(k);
      n_checks++;
      if (S !== 2'(s_m) || step !== st || dir !== dir_m) begin
        n_fails++;
        $display("FAIL auto_repeat cycle %0d: S=%0d step=%0b dir=%0b, expected S=%0d step=%0b dir=%0b",
                 k, S, step, dir, s_m, st, dir_m);
      end
    end
  endtask

  task automatic test_simultaneous();
    bit st;
    clear_window();
    add_press(1'b1, 0, 30);
    add_press(1'b0, 0, 30);
    for (int k = 0; k < 50; k++) begin
      drive(k);
      st = model_step(k);
      n_checks++;
      if (S !== 2'(s_m) || step !== st || dir !== dir_m) begin
        n_fails++;
        $display("FAIL simultaneous cycle %0d: S=%0d step=%0b dir=%0b, expected S=%0d step=%0b dir=%0b",
                 k, S, step, dir, s_m, st, dir_m);
      end
    end
  endtask

  task automatic test_random(int round);
    bit st;
    int t;
    int h;
    clear_window();
    for (int b = 0; b < 2; b++) begin
      t = int'($urandom_range(0, 10));
      forever begin
        h = int'($urandom_range(D + 2, 40));
        if (t + h > 380) break;
        add_press(b == 0, t, t + h);
        t = t + h + int'($urandom_range(D + 2, 15));
      end
    end
    for (int k = 0; k < 400; k++) begin
      drive(k);
      st = model_step(k);
      n_checks++;
      if (S !== 2'(s_m) || step !== st || dir !== dir_m) begin
        n_fails++;
        $display("FAIL random%0d cycle %0d: S=%0d step=%0b dir=%0b, expected S=%0d step=%0b dir=%0b",
                 round, k, S, step, dir, s_m, st, dir_m);
      end
    end
  endtask

  task automatic test_reset_mid_repeat();
    bit st;
    clear_window();
    add_press(1'b1, 0, 200);
    for (int k = 0; k < 25; k++) begin
      drive(k);
      st = model_step(k);
      n_checks++;
      if (S !== 2'(s_m) || step !== st || dir !== dir_m) begin
        n_fails++;
        $display("FAIL pre_reset cycle %0d: S=%0d step=%0b dir=%0b, expected S=%0d step=%0b dir=%0b",
                 k, S, step, dir, s_m, st, dir_m);
      end
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (S !== 2'd0 || step !== 1'b0 || dir !== 1'b0) begin
      n_fails++;
      $display("FAIL async_reset: S=%0d step=%0b dir=%0b, expected 0 0 0", S, step, dir);
    end
    s_m = 0; dir_m = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 45; k++) begin
      btn_next = (k < 30);
      @(posedge clk);
      #1;
      n_checks++;
      if (S !== 2'd0 || step !== 1'b0) begin
        n_fails++;
        $display("FAIL post_reset_held cycle %0d: S=%0d step=%0b, expected S=0 step=0", k, S, step);
      end
    end
    clear_window();
    add_press(1'b1, 5, 15);
    for (int k = 0; k < 30; k++) begin
      drive(k);
      st = model_step(k);
      n_checks++;
      if (S !== 2'(s_m) || step !== st || dir !== dir_m) begin
        n_fails++;
        $display("FAIL post_reset_press cycle %0d: S=%0d step=%0b dir=%0b, expected S=%0d step=%0b dir=%0b",
                 k, S, step, dir, s_m, st, dir_m);
      end
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    btn_next = 1'b0;
    btn_prev = 1'b0;
    test_reset();
    test_clean_next();
    test_bounce_prev();
    test_auto_repeat();
    test_simultaneous();
    for (int r = 0; r < 3; r++) test_random(r);
    test_reset_mid_repeat();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
